// File: rtl/rst_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rst_sync
// Reset synchronizer for a single clock domain. The local reset asserts
// asynchronously as soon as RST goes low and deasserts synchronously, on the
// NUM_STAGES-th rising edge of CLK after RST returns high.
//
// Parameters
//   NUM_STAGES : length of the synchronizer chain (deassertion latency in
//                CLK rising edges). Must be >= 2.
// Ports
//   CLK      in  destination-domain clock, rising edge
//   RST      in  asynchronous active-low reset, may change at any time
//   SYNC_RST out active-low local reset, taken straight from the last flop
// -----------------------------------------------------------------------------
module rst_sync #(
   parameter int NUM_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   output logic SYNC_RST
);

   // A single flop gives no metastability protection on the release edge,
   // so refuse to build with fewer than two stages.
   if (NUM_STAGES < 2) begin : g_bad_stages
      $error("rst_sync: NUM_STAGES must be >= 2");
   end

   logic [NUM_STAGES-1:0] r_sync;

   // The chain clears at once on RST low; once released it fills with ones
   // from bit 0. The constant '1' into bit 0 is the only data input.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[NUM_STAGES-2:0], 1'b1};
      end
   end

   // Output comes straight from a flop so no glitch can reach the domain.
   assign SYNC_RST = r_sync[NUM_STAGES-1];

endmodule

// File: tb/tb_rst_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rst_sync
// Self-checking bench for rst_sync. Two instances (NUM_STAGES = 2 and 4)
// share CLK and RST. A counting reference model predicts each SYNC_RST value
// when stimulus is driven; the prediction is queued and popped once the DUT
// has had its clock edge.
// -----------------------------------------------------------------------------
module tb_rst_sync;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b1;
    logic sr2;
    logic sr4;

    int errors = 0;
    int checks = 0;

    int m2 = 0;
    int m4 = 0;

    logic [1:0] sb[$];

    always #1 if (clk_en) clk = ~clk;

    rst_sync #(.NUM_STAGES(2)) u_dut2 (
        .CLK      (clk),
        .RST      (rst),
        .SYNC_RST (sr2)
    );

    rst_sync #(.NUM_STAGES(4)) u_dut4 (
        .CLK      (clk),
        .RST      (rst),
        .SYNC_RST (sr4)
    );

    initial begin
        #20000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int cyc, input logic [1:0] want);
        checks++;
        if ({sr4, sr2} !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d rst=%b: got sr4,sr2=%b%b want %b", tag, cyc, rst, sr4, sr2, want);
        end else begin
            $display("PASS %s cyc=%0d rst=%b: sr4,sr2=%b%b", tag, cyc, rst, sr4, sr2);
        end
    endtask

    task automatic model_reset();
        m2 = 0;
        m4 = 0;
    endtask

    task automatic predict_edge();
        if (rst) begin
            m2 = (m2 < 2) ? m2 + 1 : 2;
            m4 = (m4 < 4) ? m4 + 1 : 4;
        end else begin
            model_reset();
        end
        sb.push_back({(m4 == 4), (m2 == 2)});
    endtask

    task automatic drive_cycle(input logic r);
        @(negedge clk);
        rst = r;
        if (!r) model_reset();
        predict_edge();
        @(posedge clk);
        #0.5;
    endtask

    task automatic test_reset();
        #0.2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0);
            check("reset_hold", i, sb.pop_front());
        end
    endtask

    task automatic test_release();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1);
            check("release", i, sb.pop_front());
        end
    endtask

    task automatic test_assert_midcycle();
        rst = 1'b0;
        model_reset();
        #0.1;
        check("async_assert", 0, 2'b00);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0);
            check("assert_hold", i, sb.pop_front());
        end
    endtask

    task automatic test_reassert_during_release();
        logic [4:0] pattern;
        pattern = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(pattern[i]);
            check("reassert", i, sb.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1);
            check("reassert_tail", i, sb.pop_front());
        end
    endtask

    task automatic test_short_pulse_clock_stopped();
        @(negedge clk);
        clk_en = 1'b0;
        #0.4;
        check("pre_pulse", 0, 2'b11);
        rst = 1'b0;
        model_reset();
        #0.3;
        check("short_pulse", 0, 2'b00);
        rst = 1'b1;
        #2.3;
        check("stopped_hold", 0, 2'b00);
        clk_en = 1'b1;
        predict_edge();
        @(posedge clk);
        #0.5;
        check("restart_edge1", 1, sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1);
            check("restart", i + 2, sb.pop_front());
        end
    endtask

    task automatic test_latency_count();
        int rise2;
        int rise4;
        drive_cycle(1'b0);
        check("latency_reset", 0, sb.pop_front());
        rise2 = 0;
        rise4 = 0;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1);
            check("latency", i, sb.pop_front());
            if (sr2 === 1'b1 && rise2 == 0) rise2 = i;
            if (sr4 === 1'b1 && rise4 == 0) rise4 = i;
        end
        checks++;
        if (rise2 != 2) begin
            errors++;
            $display("FAIL latency_n2: rose on edge %0d want 2 (0 = never)", rise2);
        end else begin
            $display("PASS latency_n2: rose on edge %0d", rise2);
        end
        checks++;
        if (rise4 != 4) begin
            errors++;
            $display("FAIL latency_n4: rose on edge %0d want 4 (0 = never)", rise4);
        end else begin
            $display("PASS latency_n4: rose on edge %0d", rise4);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_assert_midcycle();
        test_reassert_during_release();
        test_short_pulse_clock_stopped();
        test_latency_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
